// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, slave write FSM states and the latched write-address request.
package axi3_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} ws_state_t;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } aw_req_t;

  function automatic logic [31:0] size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi3_burst_addr.sv
// Combinational AXI3 next-beat address generator; flags reserved bursts and illegal WRAP lengths.
module axi3_burst_addr import axi3_pkg::*; (
  input  logic [31:0] cur_addr,
  input  logic [3:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        illegal
);

  logic [31:0] step, incr, wrap_mask;

  always_comb begin
    step      = size_bytes(size);
    incr      = cur_addr + step;
    // wrap window is (len+1) beats, aligned to its own size
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    next_addr = cur_addr;
    illegal   = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP: begin
        next_addr = (cur_addr & ~wrap_mask) | (incr & wrap_mask);
        illegal   = !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
      end
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi3_write_slave.sv
// AXI3 write slave: one outstanding burst, byte-strobed word memory, registered handshakes,
// combinational debug read port.
module axi3_write_slave import axi3_pkg::*; #(
  parameter  int          DATA_W    = 32,
  parameter  int          MEM_DEPTH = 64,
  parameter  logic [31:0] BASE_ADDR = 32'd0,
  localparam int          STRB_W    = DATA_W / 8,
  localparam int          IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [3:0]        AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic [1:0]        AWLOCK,
  input  logic [3:0]        AWCACHE,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [3:0]        WID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [3:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int LB = $clog2(STRB_W);

  ws_state_t   state, state_nxt;
  aw_req_t     req;
  logic [31:0] cur_addr, next_addr, off, widx;
  logic [3:0]  beat;
  logic        err, illegal, last, in_range, size_bad, beat_err;
  logic        aw_hs, w_hs, b_hs;
  logic [STRB_W-1:0] lane_we;
  logic [MEM_DEPTH-1:0][DATA_W-1:0] mem;

  logic        awready_d, wready_d, bvalid_d;
  logic [3:0]  bid_d;
  logic [1:0]  bresp_d;

  logic unused_sideband;
  assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT};

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  axi3_burst_addr u_addr (
    .cur_addr  (cur_addr),
    .len       (req.len),
    .size      (req.size),
    .burst     (req.burst),
    .next_addr (next_addr),
    .illegal   (illegal)
  );

  assign off      = cur_addr - BASE_ADDR;
  assign widx     = off >> LB;
  assign in_range = (cur_addr >= BASE_ADDR) && (widx < 32'(MEM_DEPTH));
  assign size_bad = int'(req.size) > LB;
  assign last     = (beat == req.len);
  assign beat_err = (WID != req.id) || !in_range || size_bad || illegal || (WLAST != last);
  assign lane_we  = (w_hs && !beat_err) ? WSTRB : '0;

  // Datapath: latched request, address walker, sticky error, memory
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      req      <= '0;
      cur_addr <= '0;
      beat     <= '0;
      err      <= 1'b0;
      mem      <= '0;
    end else begin
      if (aw_hs) begin
        req      <= '{id: AWID, len: AWLEN, size: AWSIZE, burst: AWBURST};
        cur_addr <= AWADDR & ~(size_bytes(AWSIZE) - 32'd1);
        beat     <= '0;
        err      <= 1'b0;
      end
      if (w_hs) begin
        cur_addr <= next_addr;
        beat     <= beat + 4'd1;
        err      <= err | beat_err;
        for (int b = 0; b < STRB_W; b++)
          if (lane_we[b]) mem[widx[IDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Beat count, not WLAST, terminates the burst
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (aw_hs)        state_nxt = DATA;
      DATA:    if (w_hs && last) state_nxt = RESP;
      RESP:    if (b_hs)         state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    awready_d = (state_nxt == IDLE);
    wready_d  = (state_nxt == DATA);
    bvalid_d  = (state_nxt == RESP);
    bid_d     = BID;
    bresp_d   = BRESP;
    if (state == DATA && state_nxt == RESP) begin
      bid_d   = req.id;
      bresp_d = (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
    end else begin
      AWREADY <= awready_d;
      WREADY  <= wready_d;
      BVALID  <= bvalid_d;
      BID     <= bid_d;
      BRESP   <= bresp_d;
    end
  end

  always_comb begin
    dbg_data = '0;
    if (int'(dbg_addr) < MEM_DEPTH) dbg_data = mem[dbg_addr];
  end

endmodule

// File: tb/tb_axi3_write_slave.sv
// Directed bench for axi3_write_slave: expected B responses queued at issue, checked by a monitor.
module tb_axi3_write_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, WID, BID;
  logic [31:0] AWADDR, WDATA, dbg_data;
  logic [3:0]  AWLEN, AWCACHE, WSTRB;
  logic [2:0]  AWSIZE, AWPROT;
  logic [1:0]  AWBURST, AWLOCK, BRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [5:0]  dbg_addr;

  always #5 ACLK = ~ACLK;

  axi3_write_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  bexp_t bq[$];
  int checks = 0, passes = 0, b_exp = 0, b_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // B monitor: handshake completes on the posedge following this negedge
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1 && BVALID === 1'b1 && BREADY === 1'b1) begin
      bexp_t e;
      if (bq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_b: got BID %h BRESP %h, none queued", BID, BRESP);
      end else begin
        e = bq.pop_front();
        check("bid", 64'(BID), 64'(e.id));
        check("bresp", 64'(BRESP), 64'(e.resp));
      end
      b_seen++;
    end
  end

  task automatic expect_b(input logic [3:0] id, input logic [1:0] resp);
    bexp_t e;
    e.id = id;
    e.resp = resp;
    bq.push_back(e);
    b_exp++;
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) begin checks++; $display("FAIL aw_timeout: AWREADY %b required 1", AWREADY); end
    @(posedge ACLK);
    #1 AWVALID = 1'b0;
  endtask

  task automatic wbeat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                       input logic last);
    int n = 0;
    @(negedge ACLK);
    WID = id; WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!WREADY) begin checks++; $display("FAIL w_timeout: WREADY %b required 1", WREADY); end
    @(posedge ACLK);
    #1 WVALID = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (b_seen < b_exp && n < 100) begin @(negedge ACLK); n++; end
    if (b_seen < b_exp) begin checks++; $display("FAIL b_timeout: seen %0d required %0d", b_seen, b_exp); end
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    @(negedge ACLK);
    dbg_addr = 6'(idx);
    #1 d = dbg_data;
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] d;
    rd(idx, d);
    check(name, 64'(d), 64'(exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [31:0] d;
    int wrap_w[4] = '{14, 15, 12, 13};
    ARESETn = 1'b0; BREADY = 1'b1; dbg_addr = '0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    AWLOCK = '0; AWCACHE = '0; AWPROT = '0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;

    // Reset
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_outputs", 64'({AWREADY, WREADY, BVALID, BID, BRESP}), 64'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_after_reset", 64'({AWREADY, WREADY, BVALID}), 64'b100);
    bad = 0;
    for (int i = 0; i < 64; i++) begin rd(i, d); if (d !== 32'd0) bad++; end
    check("mem_cleared", 64'(bad), 64'd0);

    // INCR 4 beats to words 4..7
    expect_b(4'd3, 2'b00);
    aw(4'd3, 32'h10, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) wbeat(4'd3, 32'hA0A0_0000 + i, 4'hF, i == 3);
    wait_b();
    for (int i = 0; i < 4; i++) check_word("incr_word", 4 + i, 32'hA0A0_0000 + i);

    // WRAP 4 beats from 0x38: words 14,15,12,13
    expect_b(4'd1, 2'b00);
    aw(4'd1, 32'h38, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) wbeat(4'd1, 32'hB0B0_0000 + i, 4'hF, i == 3);
    wait_b();
    for (int i = 0; i < 4; i++) check_word("wrap_word", wrap_w[i], 32'hB0B0_0000 + i);

    // FIXED 3 beats to word 0: last beat wins
    expect_b(4'd2, 2'b00);
    aw(4'd2, 32'h0, 4'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) wbeat(4'd2, 32'hC0C0_0000 + i, 4'hF, i == 2);
    wait_b();
    check_word("fixed_word0", 0, 32'hC0C0_0002);
    check_word("fixed_word1", 1, 32'h0);

    // Partial strobe on word 2
    expect_b(4'd4, 2'b00);
    aw(4'd4, 32'h8, 4'd0, 3'd2, 2'b01);
    wbeat(4'd4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wait_b();
    expect_b(4'd4, 2'b00);
    aw(4'd4, 32'h8, 4'd0, 3'd2, 2'b01);
    wbeat(4'd4, 32'h1122_3344, 4'b0101, 1'b1);
    wait_b();
    check_word("strobe_word2", 2, 32'hFF22_FF44);

    // Out-of-range address
    expect_b(4'd5, 2'b10);
    aw(4'd5, 32'h100, 4'd0, 3'd2, 2'b01);
    wbeat(4'd5, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_b();

    // WID mismatch: no write to word 8
    expect_b(4'd6, 2'b10);
    aw(4'd6, 32'h20, 4'd0, 3'd2, 2'b01);
    wbeat(4'd7, 32'h5555_AAAA, 4'hF, 1'b1);
    wait_b();
    check_word("wid_mismatch_word8", 8, 32'h0);

    // Early WLAST on beat 1 of 4: beats 1 and 3 are errored and skipped
    expect_b(4'd7, 2'b10);
    aw(4'd7, 32'h40, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) wbeat(4'd7, 32'hD0D0_0000 + i, 4'hF, i == 1);
    wait_b();
    check_word("early_last_w16", 16, 32'hD0D0_0000);
    check_word("early_last_w17", 17, 32'h0);
    check_word("early_last_w18", 18, 32'hD0D0_0002);
    check_word("early_last_w19", 19, 32'h0);

    // BREADY stall: B held stable, AWVALID ignored
    BREADY = 1'b0;
    expect_b(4'd9, 2'b00);
    aw(4'd9, 32'h50, 4'd0, 3'd2, 2'b01);
    wbeat(4'd9, 32'h1234_5678, 4'hF, 1'b1);
    @(negedge ACLK);
    AWID = 4'd10; AWADDR = 32'h0; AWLEN = 4'd0; AWVALID = 1'b1;
    repeat (5) begin
      @(negedge ACLK);
      check("b_hold", 64'({BVALID, BID, BRESP, AWREADY}), 64'({1'b1, 4'd9, 2'b00, 1'b0}));
    end
    @(posedge ACLK);
    #1 BREADY = 1'b1; AWVALID = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("awready_after_b", 64'({AWREADY, BVALID}), 64'b10);
    wait_b();
    check_word("stall_word20", 20, 32'h1234_5678);

    // Reset mid-DATA: burst abandoned, no B
    aw(4'd2, 32'h60, 4'd3, 3'd2, 2'b01);
    wbeat(4'd2, 32'hE0E0_0000, 4'hF, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("midburst_reset", 64'({AWREADY, WREADY, BVALID}), 64'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_reset_idle", 64'({AWREADY, WREADY, BVALID}), 64'b100);
    bad = 0;
    repeat (4) begin @(negedge ACLK); if (BVALID !== 1'b0) bad++; end
    check("no_b_after_reset", 64'(bad), 64'd0);
    check_word("reset_cleared_w24", 24, 32'h0);
    check_word("reset_cleared_w4", 4, 32'h0);

    // Recovery burst
    expect_b(4'd1, 2'b00);
    aw(4'd1, 32'h4, 4'd1, 3'd2, 2'b01);
    wbeat(4'd1, 32'hF1F1_F1F1, 4'hF, 1'b0);
    wbeat(4'd1, 32'hF2F2_F2F2, 4'hF, 1'b1);
    wait_b();
    check_word("recover_w1", 1, 32'hF1F1_F1F1);
    check_word("recover_w2", 2, 32'hF2F2_F2F2);
    check("b_queue_drained", 64'(bq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
